// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: shared bit indices, scan codes, enums and rotation helper for the arcade input mapper
package arcade_input_pkg;
  localparam int J_RIGHT = 0, J_LEFT = 1, J_DOWN = 2, J_UP = 3, J_FIRE1 = 4, J_FIRE2 = 5;
  localparam int J_START = 6, J_COIN = 7, J_SERVICE = 8;
  localparam int C_DOWN = 0, C_UP = 1, C_RIGHT = 2, C_LEFT = 3, C_FIRE1 = 4, C_FIRE2 = 5;
  localparam int C_START = 6, C_W = 7;
  // arrow keys match on the low byte only, so they are 8-bit
  localparam logic [7:0] K_UP = 8'h75, K_DOWN = 8'h72, K_LEFT = 8'h6B, K_RIGHT = 8'h74;
  localparam logic [8:0] K_P0_FIRE1A = 9'h029, K_P0_FIRE1B = 9'h014, K_P0_FIRE2 = 9'h011;
  localparam logic [8:0] K_P0_STARTA = 9'h005, K_P0_STARTB = 9'h016;
  localparam logic [8:0] K_P1_UP = 9'h02D, K_P1_DOWN = 9'h02B, K_P1_LEFT = 9'h023, K_P1_RIGHT = 9'h034;
  localparam logic [8:0] K_P1_FIRE1 = 9'h01C, K_P1_FIRE2 = 9'h01B, K_P1_STARTA = 9'h006, K_P1_STARTB = 9'h01E;
  localparam logic [8:0] K_COIN0 = 9'h02E, K_COIN1 = 9'h036, K_COIN2 = 9'h03D, K_COIN3 = 9'h03E;
  localparam logic [8:0] K_SERVICE = 9'h02C;
  typedef enum logic [1:0] {ROT_NONE, ROT_A, ROT_B, ROT_180} rot_e;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_e;
  function automatic logic [6:0] rotate(input logic [6:0] r, input rot_e m);
    return m == ROT_A   ? {r[6:4], r[C_DOWN], r[C_UP], r[C_LEFT], r[C_RIGHT]} :
           m == ROT_B   ? {r[6:4], r[C_UP], r[C_DOWN], r[C_RIGHT], r[C_LEFT]} :
           m == ROT_180 ? {r[6:4], r[C_RIGHT], r[C_LEFT], r[C_DOWN], r[C_UP]} : r;
  endfunction
endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// coin_pulser: one coin channel, fixed-length pulse then enforced gap, with a one-deep pending request
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int PULSE_CYC = 2400000,
  parameter int GAP_CYC   = 2400000
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic active
);
  localparam int CW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYC - 1);
  coin_state_e state;
  logic [CW-1:0] cnt;
  logic pending;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
      active <= 1'b0;
    end else
      case (state)
        IDLE: if (req) begin
          state <= PULSE;
          cnt <= P_LOAD;
          active <= 1'b1;
        end
        PULSE: begin
          if (req) pending <= 1'b1;
          if (cnt == '0) begin
            state <= GAP;
            cnt <= G_LOAD;
            active <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        GAP: if (cnt == '0) begin
          // a request landing on the expiry cycle is served like a pending one
          state <= (pending || req) ? PULSE : IDLE;
          active <= pending || req;
          cnt <= P_LOAD;
          pending <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
          if (req) pending <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and joysticks into rotated per-player controls and paced coin pulses
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS        = 2,
  parameter int COIN_PULSE_CYC = 2400000,
  parameter int COIN_GAP_CYC   = 2400000,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   RESET,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joy_in,
  input  logic [1:0]             rot_mode,
  input  logic                   auto_coin,
  output logic [7*PLAYERS-1:0]   p_ctrl,
  output logic [PLAYERS-1:0]     coin,
  output logic                   service
);
  logic primed, old_tog, key_srv, srv_q, pr;
  logic [C_W-1:0] key_p0, key_p1;
  logic [3:0] key_coin;
  logic [7*PLAYERS-1:0] ctrl_d, ctrl_q;
  logic [PLAYERS-1:0] coin_raw, coin_prev, start, start_prev, svc, req, act;
  logic unused_bits;
  assign pr = ps2_key[9];
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      primed <= 1'b0;
      old_tog <= 1'b0;
      key_p0 <= '0;
      key_p1 <= '0;
      key_coin <= '0;
      key_srv <= 1'b0;
    end else begin
      primed <= 1'b1;
      old_tog <= ps2_key[10];
      if (primed && ps2_key[10] != old_tog)
        case (ps2_key[7:0])
          K_UP: key_p0[C_UP] <= pr;
          K_DOWN: key_p0[C_DOWN] <= pr;
          K_LEFT: key_p0[C_LEFT] <= pr;
          K_RIGHT: key_p0[C_RIGHT] <= pr;
          default:
            case (ps2_key[8:0])
              K_P0_FIRE1A, K_P0_FIRE1B: key_p0[C_FIRE1] <= pr;
              K_P0_FIRE2: key_p0[C_FIRE2] <= pr;
              K_P0_STARTA, K_P0_STARTB: key_p0[C_START] <= pr;
              K_P1_UP: key_p1[C_UP] <= pr;
              K_P1_DOWN: key_p1[C_DOWN] <= pr;
              K_P1_LEFT: key_p1[C_LEFT] <= pr;
              K_P1_RIGHT: key_p1[C_RIGHT] <= pr;
              K_P1_FIRE1: key_p1[C_FIRE1] <= pr;
              K_P1_FIRE2: key_p1[C_FIRE2] <= pr;
              K_P1_STARTA, K_P1_STARTB: key_p1[C_START] <= pr;
              K_COIN0: key_coin[0] <= pr;
              K_COIN1: key_coin[1] <= pr;
              K_COIN2: key_coin[2] <= pr;
              K_COIN3: key_coin[3] <= pr;
              K_SERVICE: key_srv <= pr;
              default: ;
            endcase
        endcase
    end
  for (genvar g = 0; g < PLAYERS; g++) begin : g_pl
    logic [C_W-1:0] key, raw;
    assign key = g == 0 ? key_p0 : g == 1 ? key_p1 : '0;
    assign raw = key | {joy_in[16*g+J_START], joy_in[16*g+J_FIRE2], joy_in[16*g+J_FIRE1],
                        joy_in[16*g+J_LEFT], joy_in[16*g+J_RIGHT], joy_in[16*g+J_UP], joy_in[16*g+J_DOWN]};
    assign ctrl_d[7*g +: 7] = rotate(raw, rot_e'(rot_mode));
    assign start[g] = raw[C_START];
    assign svc[g] = joy_in[16*g+J_SERVICE];
    assign coin_raw[g] = key_coin[g] | joy_in[16*g+J_COIN];
    coin_pulser #(.PULSE_CYC(COIN_PULSE_CYC), .GAP_CYC(COIN_GAP_CYC)) u_coin (
      .clk(clk_sys), .rst(RESET), .req(req[g]), .active(act[g])
    );
  end
  assign req = (coin_raw & ~coin_prev) | PLAYERS'(auto_coin & |(start & ~start_prev));
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      ctrl_q <= '0;
      srv_q <= 1'b0;
      coin_prev <= '0;
      start_prev <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      srv_q <= key_srv | (|svc);
      coin_prev <= coin_raw;
      start_prev <= start;
    end
  assign p_ctrl = ACTIVE_LOW ? ~ctrl_q : ctrl_q;
  assign coin = ACTIVE_LOW ? ~act : act;
  assign service = ACTIVE_LOW ? ~srv_q : srv_q;
  assign unused_bits = ^{joy_in, key_coin};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed and random stimulus checked against a cycle model of the cabinet controls
module tb_arcade_input_mapper;
  localparam int NP = 2, PC = 4, GC = 3;
  logic clk = 1'b0, rst;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic [1:0] rot_mode;
  logic auto_coin;
  logic [13:0] p_ctrl;
  logic [1:0] coin;
  logic service;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  arcade_input_mapper #(.PLAYERS(NP), .COIN_PULSE_CYC(PC), .COIN_GAP_CYC(GC), .ACTIVE_LOW(1'b1)) dut (
    .clk_sys(clk), .RESET(rst), .ps2_key(ps2_key), .joy_in(joy_in), .rot_mode(rot_mode),
    .auto_coin(auto_coin), .p_ctrl(p_ctrl), .coin(coin), .service(service)
  );
  // model: function order down,up,right,left,fire1,fire2,start; jmap gives the joystick bit of each
  int jmap[7] = '{2, 3, 0, 1, 4, 5, 6};
  int rot_src[4][4] = '{'{0, 1, 2, 3}, '{2, 3, 1, 0}, '{3, 2, 0, 1}, '{1, 0, 3, 2}};
  logic [8:0] codes[16] = '{9'h075, 9'h172, 9'h06B, 9'h174, 9'h029, 9'h014, 9'h114, 9'h011,
                            9'h016, 9'h02D, 9'h034, 9'h01E, 9'h02E, 9'h036, 9'h02C, 9'h0AA};
  bit m_primed, m_tog, ksrv, e_srv;
  bit kp[2][7], e_ctrl[2][7];
  bit kc[4];
  bit prev_coin[2], prev_start[2], pend[2];
  int ph[2], left[2];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_primed = 0; m_tog = 0; ksrv = 0; e_srv = 0;
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 7; f++) begin kp[p][f] = 0; e_ctrl[p][f] = 0; end
      prev_coin[p] = 0; prev_start[p] = 0; pend[p] = 0; ph[p] = 0; left[p] = 0;
    end
    for (int c = 0; c < 4; c++) kc[c] = 0;
  endtask
  task automatic decode(input logic [8:0] code, input bit pr);
    case (code[7:0])
      8'h75: kp[0][1] = pr;
      8'h72: kp[0][0] = pr;
      8'h74: kp[0][2] = pr;
      8'h6B: kp[0][3] = pr;
      default:
        case (code)
          9'h029, 9'h014: kp[0][4] = pr;
          9'h011: kp[0][5] = pr;
          9'h005, 9'h016: kp[0][6] = pr;
          9'h02D: kp[1][1] = pr;
          9'h02B: kp[1][0] = pr;
          9'h023: kp[1][3] = pr;
          9'h034: kp[1][2] = pr;
          9'h01C: kp[1][4] = pr;
          9'h01B: kp[1][5] = pr;
          9'h006, 9'h01E: kp[1][6] = pr;
          9'h02E: kc[0] = pr;
          9'h036: kc[1] = pr;
          9'h03D: kc[2] = pr;
          9'h03E: kc[3] = pr;
          9'h02C: ksrv = pr;
          default: ;
        endcase
    endcase
  endtask
  task automatic compare(input string tag);
    logic [13:0] ec;
    logic [1:0] ecn;
    for (int p = 0; p < 2; p++) for (int f = 0; f < 7; f++) ec[7*p+f] = !e_ctrl[p][f];
    for (int c = 0; c < 2; c++) ecn[c] = !(ph[c] == 1);
    check({tag, "_ctrl"}, 32'(p_ctrl), 32'(ec));
    check({tag, "_coin"}, 32'(coin), 32'(ecn));
    check({tag, "_service"}, 32'(service), 32'(!e_srv));
  endtask
  task automatic step(input string tag);
    bit raw[2][7];
    bit req[2];
    bit craw, any_start;
    any_start = 0;
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 7; f++) raw[p][f] = kp[p][f] | joy_in[16*p+jmap[f]];
      for (int f = 0; f < 7; f++) e_ctrl[p][f] = f < 4 ? raw[p][rot_src[rot_mode][f]] : raw[p][f];
      craw = kc[p] | joy_in[16*p+7];
      req[p] = craw & !prev_coin[p];
      prev_coin[p] = craw;
      any_start |= raw[p][6] & !prev_start[p];
      prev_start[p] = raw[p][6];
    end
    req[0] |= auto_coin & any_start;
    e_srv = ksrv | joy_in[8] | joy_in[24];
    for (int c = 0; c < 2; c++)
      case (ph[c])
        0: if (req[c]) begin ph[c] = 1; left[c] = PC; end
        1: begin
          if (req[c]) pend[c] = 1;
          left[c]--;
          if (left[c] == 0) begin ph[c] = 2; left[c] = GC; end
        end
        default: begin
          if (req[c]) pend[c] = 1;
          left[c]--;
          if (left[c] == 0) begin ph[c] = pend[c] ? 1 : 0; left[c] = PC; pend[c] = 0; end
        end
      endcase
    if (!m_primed) begin m_primed = 1; m_tog = ps2_key[10]; end
    else begin
      if (ps2_key[10] != m_tog) decode(ps2_key[8:0], ps2_key[9]);
      m_tog = ps2_key[10];
    end
    @(posedge clk);
    #1;
    compare(tag);
  endtask
  task automatic key_event(input bit pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask
  initial begin
    int lows;
    rst = 1; ps2_key = 11'h400; joy_in = '0; rot_mode = 0; auto_coin = 0;
    model_reset();
    #12;
    check("reset_pctrl", 32'(p_ctrl), 32'h3fff);
    check("reset_coin", 32'(coin), 32'h3);
    check("reset_service", 32'(service), 32'h1);
    rst = 0;
    for (int i = 0; i < 10; i++) step("idle");
    check("idle_pctrl", 32'(p_ctrl), 32'h3fff);
    key_event(1, 9'h175);
    step("kb_up1");
    check("kb_up_not_yet", 32'(p_ctrl[1]), 32'h1);
    step("kb_up2");
    check("kb_up_active", 32'(p_ctrl[1]), 32'h0);
    key_event(0, 9'h175);
    step("kb_rel1");
    step("kb_rel2");
    check("kb_up_released", 32'(p_ctrl[1]), 32'h1);
    rot_mode = 1; joy_in[1] = 1;
    step("rotA");
    check("rotA_up", 32'(p_ctrl[1]), 32'h0);
    rot_mode = 3;
    step("rot180");
    check("rot180_right", 32'(p_ctrl[2]), 32'h0);
    check("rot180_up", 32'(p_ctrl[1]), 32'h1);
    rot_mode = 0; joy_in = '0;
    step("rot_clear");
    key_event(1, 9'h02E);
    step("coinkey");
    key_event(0, 9'h02E);
    lows = 0;
    for (int i = 0; i < 12; i++) begin step("coinkey_run"); lows += coin[0] ? 0 : 1; end
    check("coin_pulse_len", 32'(lows), 32'd4);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      joy_in[7] = (i < 6) && (i % 2 == 0);
      step("coin_multi");
      lows += coin[0] ? 0 : 1;
    end
    check("coin_pending_len", 32'(lows), 32'd8);
    auto_coin = 1; joy_in[22] = 1;
    step("auto");
    check("p1_start", 32'(p_ctrl[13]), 32'h0);
    lows = coin[0] ? 0 : 1;
    for (int i = 0; i < 10; i++) begin step("auto_run"); lows += coin[0] ? 0 : 1; end
    check("auto_coin_len", 32'(lows), 32'd4);
    joy_in[22] = 0; auto_coin = 0;
    step("auto_rel");
    joy_in[22] = 1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin step("noauto"); lows += coin[0] ? 0 : 1; end
    check("noauto_coin", 32'(lows), 32'd0);
    joy_in = '0;
    step("pre_rst");
    joy_in[7] = 1;
    step("rst_pulse1");
    step("rst_pulse2");
    check("coin_mid_pulse", 32'(coin[0]), 32'h0);
    #2 rst = 1;
    #1 check("coin_async_reset", 32'(coin[0]), 32'h1);
    model_reset();
    #3 rst = 0;
    joy_in = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) joy_in = $urandom() & 32'h01FF01FF;
      if ($urandom_range(0, 7) == 0) rot_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) auto_coin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) key_event(1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]);
      step("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
